// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding request
// at a time over req/gnt/rvalid, and holds the returned word in a one-entry
// instruction register with valid/stall flow control and PC redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  logic        ir_free_s;
  logic        req_s;
  logic [31:0] fetch_pc_inc_s;

  // Request is issued only when the IR can take the word by the time it
  // returns; it depends on stall, so it stays combinational.
  always_comb begin
    ir_free_s      = !instr_valid_q || !stall;
    req_s          = !reset && (state_q == S_REQ) && ir_free_s;
    fetch_pc_inc_s = fetch_pc_q + 32'd4;
  end

  // Next-state logic: consume, response load, then redirect overrides.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;

    // Decode takes the word this cycle; a same-cycle load below wins.
    if (instr_valid_q && !stall) begin
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
    end else begin
      instr_valid_d = instr_valid_q;
    end

    case (state_q)
      S_REQ: begin
        if (req_s && imem_gnt) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            pc_d          = fetch_pc_q;
            pc_plus4_d    = fetch_pc_inc_s;
            fetch_pc_d    = fetch_pc_inc_s;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect: new fetch address, flush the IR, and mark any fetch still
    // in flight as stale so its data is thrown away.
    if (pc_src) begin
      fetch_pc_d    = pc_target & ~32'h0000_0003;
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
      if (state_q == S_WAIT) begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
        end else begin
          drop_d = 1'b1;
        end
      end else if (req_s && imem_gnt) begin
        drop_d = 1'b1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  // State and instruction-register flops with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] words [0:3];

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_ir(input string tag, input logic v, input logic [31:0] i,
                          input logic [31:0] p);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
    check_eq({tag, "_instr"}, instr, i);
    check_eq({tag, "_op"}, {25'd0, op}, {25'd0, i[6:0]});
    check_eq({tag, "_pc"}, pc, p);
    check_eq({tag, "_pc4"}, pc_plus4, p + 32'd4);
  endtask

  initial begin
    words[0] = 32'h0050_0093;
    words[1] = 32'h00A0_0113;
    words[2] = 32'h0020_81B3;
    words[3] = 32'h4031_0233;

    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    pc_src = 1'b0; pc_target = 32'd0; stall = 1'b0;
    #1;
    // Reset state
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_ir("rst", 1'b0, NOP, 32'd0);
    tick();
    reset = 1'b0; imem_gnt = 1'b1;

    // Tests 1+2: straight-line fetch of four words, gnt tied high
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("seq_req", {31'd0, imem_req}, 32'd1);
      check_eq("seq_addr", imem_addr, 32'(i * 4));
      if (i > 0) check_ir("seq_ir", 1'b1, words[i-1], 32'((i - 1) * 4));
      tick();
      imem_rvalid = 1'b1; imem_rdata = words[i];
      #1;
      check_eq("wait_req", {31'd0, imem_req}, 32'd0);
      check_eq("wait_iv", {31'd0, instr_valid}, 32'd0);
      tick();
      imem_rvalid = 1'b0;
    end
    #1;
    check_ir("seq_last", 1'b1, words[3], 32'h0000_000C);

    // Test 3: stall freezes the IR and blocks requests
    stall = 1'b1;
    #1;
    check_eq("stall_req0", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check_ir("stall_ir", 1'b1, words[3], 32'h0000_000C);
      check_eq("stall_req", {31'd0, imem_req}, 32'd0);
    end
    tick();
    stall = 1'b0;
    #1;
    check_eq("unstall_req", {31'd0, imem_req}, 32'd1);
    check_eq("unstall_addr", imem_addr, 32'h0000_0010);
    tick();
    imem_rvalid = 1'b1; imem_rdata = words[0];
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_ir("after_stall", 1'b1, words[0], 32'h0000_0010);

    // Test 4: redirect while waiting drops the returning word
    tick();                       // request 0x14 granted -> WAIT
    pc_src = 1'b1; pc_target = 32'h0000_0102;
    tick();
    pc_src = 1'b0;
    #1;
    check_eq("rd4_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("rd4_instr", instr, NOP);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_eq("rd4_drop_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("rd4_req", {31'd0, imem_req}, 32'd1);
    check_eq("rd4_addr", imem_addr, 32'h0000_0100);
    tick();
    #1;
    check_eq("rd4_wait_iv", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = words[1];
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_ir("rd4_ir", 1'b1, words[1], 32'h0000_0100);

    // Test 5a: redirect coincident with req && gnt
    check_eq("rd5a_req", {31'd0, imem_req}, 32'd1);
    check_eq("rd5a_addr", imem_addr, 32'h0000_0104);
    pc_src = 1'b1; pc_target = 32'h0000_0200;
    tick();
    pc_src = 1'b0;
    #1;
    check_eq("rd5a_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("rd5a_wreq", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_eq("rd5a_drop_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("rd5a_addr2", imem_addr, 32'h0000_0200);
    check_eq("rd5a_req2", {31'd0, imem_req}, 32'd1);
    tick();                       // request 0x200 granted -> WAIT

    // Test 5b: redirect coincident with rvalid, no valid pulse
    imem_rvalid = 1'b1; imem_rdata = words[2];
    pc_src = 1'b1; pc_target = 32'h0000_0300;
    tick();
    imem_rvalid = 1'b0; pc_src = 1'b0;
    #1;
    check_eq("rd5b_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("rd5b_instr", instr, NOP);
    check_eq("rd5b_req", {31'd0, imem_req}, 32'd1);
    check_eq("rd5b_addr", imem_addr, 32'h0000_0300);
    tick();                       // request 0x300 granted -> WAIT

    // Test 6: redirect to top of address space, pc_plus4 wraps
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFE;
    tick();
    pc_src = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = words[3];
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_ir("wrap_ir", 1'b1, words[3], 32'hFFFF_FFFC);
    check_eq("wrap_pc4", pc_plus4, 32'h0000_0000);
    check_eq("wrap_addr2", imem_addr, 32'h0000_0000);
    tick();                       // request 0x0 granted -> WAIT, IR consumed

    // Reset asserted mid-WAIT takes effect immediately
    reset = 1'b1;
    #1;
    check_eq("mrst_req", {31'd0, imem_req}, 32'd0);
    check_ir("mrst", 1'b0, NOP, 32'd0);
    check_eq("mrst_addr", imem_addr, 32'd0);
    tick();
    reset = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_eq("stray_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("stray_req", {31'd0, imem_req}, 32'd1);
    check_eq("stray_addr", imem_addr, 32'd0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = words[0];
    tick();
    imem_rvalid = 1'b0;
    #1;
    check_ir("post_rst", 1'b1, words[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
